// File: rtl/ar_arb_pkg.sv
// Package: ar_arb_pkg
// Shared AR payload type and width helpers for the AR source arbiter and the incoming
// request buffer that consumes its output.
//  ar_entry_t : packed AR payload {id, addr, len, size, burst, qos}
//  src_w(n)   : width of a source index for n sources
//  cnt_w(m)   : width of a credit counter able to hold 0..m
package ar_arb_pkg;

  localparam int unsigned ID_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned LEN_WIDTH   = 8;
  localparam int unsigned SIZE_WIDTH  = 3;
  localparam int unsigned BURST_WIDTH = 2;
  localparam int unsigned QOS_WIDTH   = 4;

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;
  } ar_entry_t;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ar_if.sv
// Interface: ar_if
// Single AR channel (valid/ready handshake plus packed payload).
//  sender   : drives valid and ar, samples ready
//  receiver : samples valid and ar, drives ready
interface ar_if;
  import ar_arb_pkg::*;

  logic      valid;
  logic      ready;
  ar_entry_t ar;

  modport sender (output valid, output ar, input ready);
  modport receiver (input valid, input ar, output ready);

endinterface

// File: rtl/rr_pick.sv
// Module: rr_pick
// Combinational rotate-priority finder: returns the first set request bit when scanning
// start_i, start_i+1, ... modulo N.
//  req_i   : request vector
//  start_i : index with highest priority
//  idx_o   : index of the first request found (0 when none)
//  found_o : at least one request is set
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  logic [31:0]     pos;
  logic [IdxW-1:0] p;

  // Scan from the farthest offset back to start_i so the nearest request is written last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    p       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(start_i) + (N - 1 - k)) % N;
      p   = IdxW'(pos);
      if (req_i[p]) begin
        idx_o   = p;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_source_arbiter.sv
// Module: ar_source_arbiter
// Round-robin arbiter sharing one AR path among NUM_SRC masters, with a per-source
// outstanding-read credit limit (MAX_OUT) freed by R-side completion reports. A grant that
// meets back-pressure is held until accepted so valid/payload stay stable.
// Optional feature: define AR_SOURCE_ARBITER_QOS_EN to make a new (IDLE) arbitration pick the
// eligible source with the highest qos, round-robin among equal qos. A held grant is never
// preempted.
// Ports:
//  clk, rst   : clock, synchronous active-high reset
//  in_valid   : per-source AR valid
//  in_ready   : per-source AR ready (only the winner sees ar_out.ready)
//  in_ar      : per-source AR payload
//  ar_out     : arbitrated AR channel toward the request buffer
//  out_src    : source index of the current ar_out beat (0 when not valid)
//  done_valid : one read completed for done_src, returns one credit
//  done_src   : source of the completed read
module ar_source_arbiter
  import ar_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned MAX_OUT = 8,
  localparam int unsigned SRC_W  = src_w(NUM_SRC),
  localparam int unsigned CNT_W  = cnt_w(MAX_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic      [NUM_SRC-1:0]  in_valid,
  output logic      [NUM_SRC-1:0]  in_ready,
  input  ar_entry_t [NUM_SRC-1:0]  in_ar,
  ar_if.sender                     ar_out,
  output logic      [SRC_W-1:0]    out_src,
  input  logic                     done_valid,
  input  logic      [SRC_W-1:0]    done_src
);

  localparam logic [SRC_W-1:0] LastSrc = SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_OUT);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pick_req;
  logic [NUM_SRC-1:0] inc_vec;
  logic [NUM_SRC-1:0] dec_vec;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_found;
  logic [SRC_W-1:0]   winner;
  logic               out_valid;
  logic               handshake;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    return (idx == LastSrc) ? '0 : idx + SRC_W'(1);
  endfunction

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      eligible[i] = in_valid[i] & (cnt_q[i] != CntMax);
    end
  end

`ifdef AR_SOURCE_ARBITER_QOS_EN
  logic [QOS_WIDTH-1:0] max_qos;

  // Narrow the request set to the highest-qos eligible sources; rr_pick breaks ties.
  always_comb begin
    max_qos  = '0;
    pick_req = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (in_ar[i].qos > max_qos)) begin
        max_qos = in_ar[i].qos;
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pick_req[i] = eligible[i] & (in_ar[i].qos == max_qos);
    end
  end
`else
  assign pick_req = eligible;
`endif

  rr_pick #(
    .N    (NUM_SRC),
    .IdxW (SRC_W)
  ) u_rr_pick (
    .req_i   (pick_req),
    .start_i (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Reset forces the channel quiet even mid-HOLD.
  always_comb begin
    winner    = '0;
    out_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          winner    = pick_idx;
          out_valid = pick_found;
        end
        StHold: begin
          winner    = grant_q;
          out_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign handshake = out_valid & ar_out.ready;

  always_comb begin
    in_ready     = '0;
    ar_out.valid = out_valid;
    ar_out.ar    = '0;
    out_src      = '0;
    if (out_valid) begin
      ar_out.ar        = in_ar[winner];
      out_src          = winner;
      in_ready[winner] = ar_out.ready;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          rr_ptr_d = wrap_inc(winner);
        end else if (out_valid) begin
          grant_d = winner;
          state_d = StHold;
        end
      end
      StHold: begin
        if (handshake) begin
          rr_ptr_d = wrap_inc(grant_q);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A completion for a source with no credits in use is dropped to avoid underflow.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      inc_vec[i] = handshake & (winner == SRC_W'(i));
      dec_vec[i] = done_valid & (done_src == SRC_W'(i)) & (cnt_q[i] != '0);
      cnt_d[i]   = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  done_no_underflow_a: assert property (@(posedge clk) disable iff (rst)
    done_valid |-> (cnt_q[done_src] != '0));

  hold_valid_stable_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == StHold) |-> in_valid[grant_q]);
`endif

endmodule

// File: tb/tb_ar_source_arbiter.sv
module tb_ar_source_arbiter;
  import ar_arb_pkg::*;

  localparam int N      = 4;
  localparam int MaxOut = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic      [N-1:0]    in_valid;
  logic      [N-1:0]    in_ready;
  ar_entry_t [N-1:0]    in_ar;
  logic      [1:0]      out_src;
  logic                 done_valid;
  logic      [1:0]      done_src;
  logic                 out_ready;

  always #5 clk = ~clk;

  ar_if u_ar ();
  assign u_ar.ready = out_ready;

  ar_source_arbiter #(
    .NUM_SRC (N),
    .MAX_OUT (MaxOut)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ar      (in_ar),
    .ar_out     (u_ar),
    .out_src    (out_src),
    .done_valid (done_valid),
    .done_src   (done_src)
  );

  int total = 0;
  int bad   = 0;

  logic       check_en = 1'b0;
  logic       lit_en   = 1'b0;
  logic       lit_v    = 1'b0;
  logic [1:0] lit_s    = 2'd0;

  // Reference model: which source owns the channel, where the rotation starts, credits in use.
  bit         m_hold;
  logic [1:0] m_grant;
  logic [1:0] m_ptr;
  int         m_cnt [N];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [1:0] w;
    logic [1:0] s;
    bit         v;
    logic [N-1:0] exp_rdy;
    ar_entry_t  exp_ar;
    if (check_en) begin
      w = 2'd0;
      v = 1'b0;
      if (!rst) begin
        if (m_hold) begin
          w = m_grant;
          v = 1'b1;
        end else begin
          for (int k = 0; k < N; k++) begin
            s = m_ptr + 2'(k);
            if (in_valid[s] && (m_cnt[s] < MaxOut)) begin
`ifdef AR_SOURCE_ARBITER_QOS_EN
              if (!v || (in_ar[s].qos > in_ar[w].qos)) w = s;
`else
              if (!v) w = s;
`endif
              v = 1'b1;
            end
          end
        end
      end
      exp_rdy = (v && out_ready) ? (4'(1) << w) : 4'd0;
      exp_ar  = v ? in_ar[w] : '0;

      chk("valid", 128'(u_ar.valid), 128'(v));
      chk("out_src", 128'(out_src), 128'(v ? w : 2'd0));
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("payload", 128'(u_ar.ar), 128'(exp_ar));
      if (lit_en) begin
        chk("lit_valid", 128'(u_ar.valid), 128'(lit_v));
        if (lit_v) chk("lit_src", 128'(out_src), 128'(lit_s));
      end

      if (rst) begin
        m_hold  = 1'b0;
        m_grant = 2'd0;
        m_ptr   = 2'd0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
        if (done_valid && (m_cnt[done_src] > 0)) m_cnt[done_src]--;
        if (v && out_ready) begin
          m_cnt[w]++;
          m_ptr  = w + 2'd1;
          m_hold = 1'b0;
        end else if (v && !m_hold) begin
          m_hold  = 1'b1;
          m_grant = w;
        end
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] v, input logic rdy, input logic dv,
                      input logic [1:0] ds, input logic le, input logic lv, input logic [1:0] ls);
    @(posedge clk);
    #1;
    rst        = r;
    in_valid   = v;
    out_ready  = rdy;
    done_valid = dv;
    done_src   = ds;
    lit_en     = le;
    lit_v      = lv;
    lit_s      = ls;
  endtask

`ifdef AR_SOURCE_ARBITER_QOS_EN
  localparam logic [1:0] T6AFirst  = 2'd2;
  localparam logic [1:0] T6BSecond = 2'd2;
`else
  localparam logic [1:0] T6AFirst  = 2'd0;
  localparam logic [1:0] T6BSecond = 2'd0;
`endif

  initial begin
    rst        = 1'b1;
    in_valid   = '0;
    out_ready  = 1'b0;
    done_valid = 1'b0;
    done_src   = 2'd0;
    for (int i = 0; i < N; i++) begin
      in_ar[i].id    = 32'h1000_0000 + 32'(i);
      in_ar[i].addr  = 32'h8000_0000 + 32'(i * 256);
      in_ar[i].len   = 8'(i + 1);
      in_ar[i].size  = 3'd2;
      in_ar[i].burst = 2'd1;
      in_ar[i].qos   = 4'd0;
    end
    check_en = 1'b1;

    // 1: reset with everything requesting, then strict rotation until credits run out.
    for (int k = 0; k < 3; k++) step(1, 4'b1111, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 4'b1111, 1, 0, 0, 1, 1, 2'(k));
    step(0, 4'b1111, 1, 0, 0, 1, 0, 0);

    // 2: back-pressure holds src1 even when src0 appears; then src2 follows.
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0110, 0, 0, 0, 1, 1, 1);
    step(0, 4'b0110, 0, 0, 0, 1, 1, 1);
    step(0, 4'b0111, 0, 0, 0, 1, 1, 1);
    step(0, 4'b0111, 0, 0, 0, 1, 1, 1);
    step(0, 4'b0111, 1, 0, 0, 1, 1, 1);
    step(0, 4'b0101, 1, 0, 0, 1, 1, 2);
    step(0, 4'b0001, 1, 0, 0, 1, 1, 0);

    // 3: credit limit on src0 and one credit returned.
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0001, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0001, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0001, 1, 0, 0, 1, 0, 0);
    step(0, 4'b0001, 1, 1, 0, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0001, 1, 0, 0, 1, 0, 0);

    // 4: handshake and completion on src3 in the same cycle leave its count unchanged.
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(0, 4'b1000, 1, 0, 0, 1, 1, 3);
    step(0, 4'b1000, 1, 1, 3, 1, 1, 3);
    step(0, 4'b1000, 1, 0, 0, 1, 1, 3);
    step(0, 4'b1000, 1, 0, 0, 1, 0, 0);

    // 5: reset in the middle of a HOLD on src2 clears pointer, grant and credits.
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0001, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0100, 0, 0, 0, 1, 1, 2);
    step(0, 4'b0100, 0, 0, 0, 1, 1, 2);
    step(1, 4'b0100, 1, 0, 0, 1, 0, 0);
    step(0, 4'b0101, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0101, 1, 0, 0, 1, 1, 2);
    step(0, 4'b0101, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0101, 1, 0, 0, 1, 1, 2);
    step(0, 4'b0101, 1, 0, 0, 1, 0, 0);

    // 6: qos mix src0=1, src2=7, src3=7, first from pointer 0 then from pointer 3.
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    in_ar[0].qos = 4'd1;
    in_ar[2].qos = 4'd7;
    in_ar[3].qos = 4'd7;
    step(0, 4'b1101, 1, 0, 0, 1, 1, T6AFirst);
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0100, 1, 0, 0, 1, 1, 2);
    step(0, 4'b1101, 1, 0, 0, 1, 1, 3);
    step(0, 4'b1101, 1, 0, 0, 1, 1, T6BSecond);
    for (int k = 0; k < 4; k++) step(0, 4'b1101, 1, 0, 0, 0, 0, 0);

    step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
